// File: rtl/sprite_ram_loader_if.sv
// rtl/sprite_ram_loader_if.sv - byte stream valid/ready handshake into the sprite loader
interface sprite_ram_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sprite_ram_loader.sv
// rtl/sprite_ram_loader.sv - streams RGB frames into sprite RAM, serves registered SpriteX/Y reads
// Optional frame checksum byte enabled by defining SPRITE_LOADER_CHECKSUM_EN.
module sprite_ram_loader #(
    parameter int         MAX_W     = 32,
    parameter int         MAX_H     = 32,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                 Clk,
    input  logic                 Reset,
    sprite_ram_loader_if.slave   inBus,
    input  logic [9:0]           SpriteX,
    input  logic [9:0]           SpriteY,
    output logic [7:0]           SpriteR,
    output logic [7:0]           SpriteG,
    output logic [7:0]           SpriteB,
    output logic [7:0]           sprite_w,
    output logic [7:0]           sprite_h,
    output logic                 sprite_valid,
    output logic                 load_done,
    output logic                 load_err
);
    localparam int DEPTH = MAX_W * MAX_H;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE, HDR_W, HDR_H, PIXEL,
`ifdef SPRITE_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE, ERR
    } state_t;

    state_t        state, stateNext;
    logic          inReadyQ, acceptNext, fire, hdrBad, lastPix, pixWrite, rdHit;
    logic [7:0]    latchW, latchH, xPos, yPos, holdR, holdG;
    logic [1:0]    phase;
    logic [AW-1:0] wrAddr, rdAddr;
    logic [23:0]   spriteRam [DEPTH];
`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    // in_ready is registered so it stays low while Reset is held and rises one cycle later
    assign inBus.in_ready = inReadyQ;
    assign fire      = inBus.in_valid && inReadyQ;
    assign hdrBad    = (latchW == 8'd0) || (inBus.in_data == 8'd0) ||
                       (int'(latchW) > MAX_W) || (int'(inBus.in_data) > MAX_H);
    assign lastPix   = (xPos == latchW - 8'd1) && (yPos == latchH - 8'd1);
    assign pixWrite  = fire && (state == PIXEL) && (phase == 2'd2);
    assign wrAddr    = AW'(yPos) * AW'(MAX_W) + AW'(xPos);
    assign rdAddr    = AW'(SpriteY) * AW'(MAX_W) + AW'(SpriteX);
    assign rdHit     = sprite_valid && (SpriteX < {2'b00, sprite_w}) && (SpriteY < {2'b00, sprite_h});
    assign load_done = (state == DONE);
    assign load_err  = (state == ERR);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (fire && inBus.in_data == SYNC_BYTE) stateNext = HDR_W;
            HDR_W: if (fire) stateNext = HDR_H;
            HDR_H: if (fire) stateNext = hdrBad ? ERR : PIXEL;
            PIXEL: if (pixWrite && lastPix) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                stateNext = CSUM;
`else
                stateNext = DONE;
`endif
            end
`ifdef SPRITE_LOADER_CHECKSUM_EN
            CSUM:  if (fire) stateNext = (inBus.in_data == csum) ? DONE : ERR;
`endif
            DONE:  stateNext = IDLE;
            ERR:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        acceptNext = !((stateNext == DONE) || (stateNext == ERR));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            inReadyQ     <= 1'b0;
            latchW       <= '0;
            latchH       <= '0;
            xPos         <= '0;
            yPos         <= '0;
            phase        <= '0;
            holdR        <= '0;
            holdG        <= '0;
            sprite_w     <= '0;
            sprite_h     <= '0;
            sprite_valid <= 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            state    <= stateNext;
            inReadyQ <= acceptNext;
            if (fire) begin
                case (state)
                    HDR_W: begin
                        latchW       <= inBus.in_data;
                        sprite_valid <= 1'b0;
                    end
                    HDR_H: begin
                        latchH <= inBus.in_data;
                        xPos   <= '0;
                        yPos   <= '0;
                        phase  <= '0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
                        csum   <= '0;
`endif
                    end
                    PIXEL: begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                        csum <= csum + inBus.in_data;
`endif
                        case (phase)
                            2'd0:    begin holdR <= inBus.in_data; phase <= 2'd1; end
                            2'd1:    begin holdG <= inBus.in_data; phase <= 2'd2; end
                            default: begin
                                phase <= 2'd0;
                                if (xPos == latchW - 8'd1) begin
                                    xPos <= '0;
                                    yPos <= yPos + 8'd1;
                                end else begin
                                    xPos <= xPos + 8'd1;
                                end
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
            // Publish on entry so sprite_valid is already high during the load_done cycle
            if (stateNext == DONE) begin
                sprite_valid <= 1'b1;
                sprite_w     <= latchW;
                sprite_h     <= latchH;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (pixWrite) spriteRam[wrAddr] <= {holdR, holdG, inBus.in_data};
    end

    // Same-cycle read of a location being written sees the old word
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            {SpriteR, SpriteG, SpriteB} <= '0;
        end else if (rdHit) begin
            {SpriteR, SpriteG, SpriteB} <= spriteRam[rdAddr];
        end else begin
            {SpriteR, SpriteG, SpriteB} <= '0;
        end
    end
endmodule

// File: tb/tb_sprite_ram_loader.sv
// tb/tb_sprite_ram_loader.sv - randomized frame loads against a behavioural sprite store model
module tb_sprite_ram_loader;
    localparam int MAX_W = 32;
    localparam int MAX_H = 32;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] SpriteX = '0, SpriteY = '0;
    logic [7:0] SpriteR, SpriteG, SpriteB, sprite_w, sprite_h;
    logic       sprite_valid, load_done, load_err;

    sprite_ram_loader_if bus();

    sprite_ram_loader #(.MAX_W(MAX_W), .MAX_H(MAX_H), .SYNC_BYTE(8'hA5)) dut (
        .Clk(Clk), .Reset(Reset), .inBus(bus.slave),
        .SpriteX(SpriteX), .SpriteY(SpriteY),
        .SpriteR(SpriteR), .SpriteG(SpriteG), .SpriteB(SpriteB),
        .sprite_w(sprite_w), .sprite_h(sprite_h), .sprite_valid(sprite_valid),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 Clk = ~Clk;

    int vectors = 0, miscompares = 0;
    int doneSeen = 0, errSeen = 0;
    logic [23:0] refRam [MAX_W*MAX_H];
    int refW = 0, refH = 0;
    bit refValid = 1'b0;
    int expDone = 0, expErr = 0;
    logic [7:0] frameQ[$];

    always @(negedge Clk) begin
        if (load_done) doneSeen++;
        if (load_err)  errSeen++;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Interpret frameQ as the loader should: skip to sync, header, pixels, optional checksum
    task automatic modelFrame();
        int i = 0;
        int w, h, p, sum;
        while (i < frameQ.size() && frameQ[i] != 8'hA5) i++;
        if (i + 2 >= frameQ.size()) return;
        w = frameQ[i+1];
        h = frameQ[i+2];
        refValid = 1'b0;
        if (w == 0 || h == 0 || w > MAX_W || h > MAX_H) begin
            expErr++;
            return;
        end
        p = i + 3;
        sum = 0;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                refRam[y*MAX_W + x] = {frameQ[p], frameQ[p+1], frameQ[p+2]};
                sum += frameQ[p] + frameQ[p+1] + frameQ[p+2];
                p += 3;
            end
`ifdef SPRITE_LOADER_CHECKSUM_EN
        if (frameQ[p] != 8'(sum)) begin
            expErr++;
            return;
        end
`endif
        refValid = 1'b1;
        refW = w;
        refH = h;
        expDone++;
    endtask

    task automatic buildFrame(input int w, input int h);
        int sum = 0;
        logic [7:0] b;
        frameQ = {8'hA5, 8'(w), 8'(h)};
        if (w == 0 || h == 0 || w > MAX_W || h > MAX_H) return;
        for (int k = 0; k < 3*w*h; k++) begin
            b = 8'($urandom);
            frameQ.push_back(b);
            sum += b;
        end
`ifdef SPRITE_LOADER_CHECKSUM_EN
        frameQ.push_back(8'(sum));
`endif
    endtask

    task automatic appendChecksum();
`ifdef SPRITE_LOADER_CHECKSUM_EN
        int sum = 0;
        for (int k = 3; k < frameQ.size(); k++) sum += frameQ[k];
        frameQ.push_back(8'(sum));
`endif
    endtask

    task automatic sendQ(input int gapPct, input int nBytes);
        int t;
        for (int k = 0; k < nBytes && k < frameQ.size(); k++) begin
            for (int g = 0; g < 4 && $urandom_range(99) < gapPct; g++) begin
                @(negedge Clk);
                bus.in_valid = 1'b0;
            end
            @(negedge Clk);
            bus.in_valid = 1'b1;
            bus.in_data  = frameQ[k];
            t = 0;
            while (!bus.in_ready && t < 50) begin
                @(negedge Clk);
                t++;
            end
            if (t == 50) checkVal("ready_timeout", 32'd0, 32'd1);
            @(posedge Clk);
        end
        @(negedge Clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic runFrame(input string tag, input int gapPct);
        int d0 = doneSeen, e0 = errSeen;
        expDone = 0;
        expErr  = 0;
        modelFrame();
        sendQ(gapPct, frameQ.size());
        repeat (4) @(negedge Clk);
        checkVal({tag, "_done"}, doneSeen - d0, expDone);
        checkVal({tag, "_err"}, errSeen - e0, expErr);
        checkVal({tag, "_valid"}, sprite_valid, refValid);
        checkVal({tag, "_w"}, sprite_w, refW);
        checkVal({tag, "_h"}, sprite_h, refH);
    endtask

    task automatic readCheck(input int x, input int y);
        logic [23:0] exp;
        @(negedge Clk);
        SpriteX = 10'(x);
        SpriteY = 10'(y);
        @(posedge Clk);
        @(negedge Clk);
        exp = (refValid && x < refW && y < refH) ? refRam[y*MAX_W + x] : 24'd0;
        checkVal($sformatf("rgb(%0d,%0d)", x, y), {SpriteR, SpriteG, SpriteB}, exp);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge Clk);
        checkVal("rst_ready", bus.in_ready, 0);
        checkVal("rst_rgb", {SpriteR, SpriteG, SpriteB}, 0);
        checkVal("rst_w", sprite_w, 0);
        checkVal("rst_h", sprite_h, 0);
        checkVal("rst_valid", sprite_valid, 0);
        checkVal("rst_done", load_done, 0);
        checkVal("rst_err", load_err, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checkVal("idle_ready", bus.in_ready, 1);

        frameQ = {8'hA5, 8'h02, 8'h02};
        for (int k = 1; k <= 12; k++) frameQ.push_back(8'(16*k));
        appendChecksum();
        runFrame("f2x2", 0);
        readCheck(1, 1);
        readCheck(2, 0);
        readCheck(0, 5);
        readCheck(0, 0);

        frameQ = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h04};
        runFrame("w0", 0);
        checkVal("w0_ready", bus.in_ready, 1);
        readCheck(0, 0);

        frameQ = {8'hA5, 8'h21, 8'h01};
        runFrame("w33", 0);
        frameQ = {8'hA5, 8'h01, 8'h01, 8'h11, 8'h22, 8'h33};
        appendChecksum();
        runFrame("f1x1", 0);
        readCheck(0, 0);

`ifdef SPRITE_LOADER_CHECKSUM_EN
        frameQ = {8'hA5, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h06};
        runFrame("csum_ok", 0);
        frameQ = {8'hA5, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h07};
        runFrame("csum_bad", 0);
        readCheck(0, 0);
`endif

        buildFrame(4, 3);
        runFrame("f4x3", 40);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 5; x++) readCheck(x, y);

        buildFrame(5, 5);
        sendQ(30, 20);
        @(negedge Clk);
        Reset = 1'b1;
        refValid = 1'b0;
        refW = 0;
        refH = 0;
        #1;
        checkVal("mid_rst_ready", bus.in_ready, 0);
        checkVal("mid_rst_valid", sprite_valid, 0);
        checkVal("mid_rst_rgb", {SpriteR, SpriteG, SpriteB}, 0);
        @(negedge Clk);
        Reset = 1'b0;
        checkVal("mid_rst_w", sprite_w, 0);
        readCheck(0, 0);
        readCheck(3, 2);
        buildFrame(1, 1);
        runFrame("post_rst", 25);
        readCheck(0, 0);
        readCheck(1, 0);

        buildFrame(32, 32);
        runFrame("f32x32", 10);
        readCheck(31, 31);
        readCheck(32, 31);
        readCheck(31, 32);
        readCheck(0, 0);

        for (int n = 0; n < 6; n++) begin
            buildFrame($urandom_range(0, 34), $urandom_range(0, 34));
            runFrame($sformatf("rnd%0d", n), 20);
            for (int r = 0; r < 8; r++) readCheck($urandom_range(0, 35), $urandom_range(0, 35));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sprite_ram_loader.md
Name: sprite_ram_loader

Overview:
- Write-side counterpart of the sprite ROM tables: accepts a byte stream of RGB pixels over a valid/ready handshake and stores it in an on-chip sprite RAM.
- Exposes the same SpriteX/SpriteY -> SpriteR/G/B read interface to the color mapper, so sprites can be loaded at run time (e.g. from NIOS or UART) instead of being baked into generated tables.
- Read port is registered: 1-cycle latency.

Parameters:
- MAX_W, 32, maximum sprite width in pixels; also the RAM row pitch.
- MAX_H, 32, maximum sprite height in pixels.
- SYNC_BYTE, 8'hA5, header byte that starts a frame.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- SpriteX  in  10  read column
- SpriteY  in  10  read row
- SpriteR  out  8  red at (SpriteX, SpriteY), registered
- SpriteG  out  8  green, registered
- SpriteB  out  8  blue, registered
- sprite_w  out  8  width of the loaded sprite
- sprite_h  out  8  height of the loaded sprite
- sprite_valid  out  1  a complete sprite is resident
- load_done  out  1  one-cycle pulse when a frame completes
- load_err  out  1  one-cycle pulse on a rejected frame

Behaviour:
- Reset values: in_ready=0, SpriteR/G/B=0, sprite_w=0, sprite_h=0, sprite_valid=0, load_done=0, load_err=0, state=IDLE. RAM contents are not cleared.
- Handshake: a byte transfers on a rising Clk edge when in_valid && in_ready. in_ready=1 in IDLE, HDR_W, HDR_H and PIXEL; in_ready=0 in DONE and ERR.
- Frame format: SYNC_BYTE, W, H, then W*H pixels, each sent as 3 bytes in R, G, B order, raster order, row 0 first.
- IDLE: bytes other than SYNC_BYTE are discarded. SYNC_BYTE -> HDR_W.
- HDR_W: latch W; clear sprite_valid -> HDR_H.
- HDR_H: latch H.
  - W==0, H==0, W>MAX_W or H>MAX_H -> ERR.
  - Otherwise clear x, y and the byte phase -> PIXEL.
- PIXEL:
  - Phase 0 and phase 1 hold R and G in a holding register.
  - Phase 2 writes {R,G,B} (24 bits) to RAM at address y*MAX_W + x, then x++.
  - When x==W-1, x wraps to 0 and y++.
  - The write of pixel (W-1, H-1) -> DONE.
- DONE: exactly 1 cycle. load_done=1, sprite_valid=1, sprite_w/sprite_h take W/H -> IDLE.
- ERR: exactly 1 cycle. load_err=1, sprite_valid stays 0 -> IDLE.
- sprite_w and sprite_h hold the last good values until the next DONE.
- Read port:
  - Registered output updates every cycle.
  - If sprite_valid==1 and SpriteX<sprite_w and SpriteY<sprite_h, the outputs one cycle later equal RAM[SpriteY*MAX_W+SpriteX].
  - Otherwise the outputs are 0.
  - Reads during a load therefore return 0 once HDR_W has been accepted.
- Address arithmetic uses $clog2(MAX_W*MAX_H) bits. x and y are 8 bits; they cannot overflow because W and H are checked against the maximums.
- A write and a read of the same address in one cycle returns the old data (read-before-write).
- Reset mid-frame: immediate return to IDLE with all outputs at their reset values; the partial frame is discarded.
- SYNC_BYTE appearing inside PIXEL data is treated as data; there is no mid-frame resync.

Optional Feature:
- Macro: SPRITE_LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the last pixel byte, the FSM enters CSUM and accepts one extra byte.
  - The expected byte is the 8-bit modulo-256 sum of all 3*W*H pixel bytes.
  - Match -> DONE. Mismatch -> ERR: sprite_valid stays 0 and sprite_w/sprite_h are unchanged.
- Without the macro: no CSUM state; the last pixel byte goes directly to DONE.

Test Plan:
- Reset, then stream A5 02 02 followed by 12 bytes 10 20 30 .. C0 with in_valid held high -> load_done pulses once; sprite_w=2, sprite_h=2, sprite_valid=1; reading (1,1) gives R=A0, G=B0, B=C0 one cycle later.
- After a valid load, read (2,0) and (0,5) -> RGB=0 for both; read (0,0) -> 10/20/30.
- Stream 00 FF A5 00 04 -> the first two bytes are ignored; load_err pulses after the H byte; sprite_valid=0; the FSM returns to IDLE with in_ready=1.
- Stream A5 21 01 with MAX_W=32 -> load_err. Then stream A5 01 01 11 22 33 -> load_done; read (0,0) gives 11/22/33.
- Toggle in_valid randomly during a 4x3 load, and assert Reset for 1 cycle halfway through a second load -> all outputs read 0 after reset; a fresh 1x1 load then succeeds.
- With SPRITE_LOADER_CHECKSUM_EN defined:
  - A5 01 01 01 02 03 06 -> load_done.
  - The same frame with checksum 07 -> load_err and sprite_valid=0.
